// File: rtl/shift_add_unit.sv
// Registered shift-then-add step: (a << shamt) + b + cin.
// Log2 barrel shifter feeding a ripple-carry adder, one register stage.
module shift_add_unit #(
  parameter int WIDTH   = 48,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  output logic [WIDTH-1:0]   shifted,
  output logic [WIDTH-1:0]   sum,
  output logic               cout
);

  logic [SHAMT_W:0][WIDTH-1:0] stg;
  logic [WIDTH-1:0]            sh_d;
  logic [WIDTH-1:0]            sum_d;
  logic [WIDTH:0]              c;

  logic             valid_q;
  logic [WIDTH-1:0] shifted_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  assign stg[0] = a;

  // Stage k shifts by 2**k; stages wider than WIDTH zero the word.
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_sh
    localparam int SH = 1 << k;
    if (SH >= WIDTH) begin : g_zero
      assign stg[k+1] = shamt[k] ? '0 : stg[k];
    end else begin : g_shift
      assign stg[k+1] = shamt[k] ? {stg[k][WIDTH-1-SH:0], {SH{1'b0}}}
                                 : stg[k];
    end
  end

  assign sh_d = stg[SHAMT_W];
  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum_d[i] = sh_d[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (sh_d[i] & b[i]) | (sh_d[i] & c[i]) | (b[i] & c[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      shifted_q <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        shifted_q <= sh_d;
        sum_q     <= sum_d;
        cout_q    <= c[WIDTH];
      end
    end
  end

  assign out_valid = valid_q;
  assign shifted   = shifted_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_shift_add_unit.sv
// Self-checking bench for shift_add_unit at WIDTH=48 and WIDTH=64.
// Table vectors, hand sequences and a randomized arithmetic reference.
module tb_shift_add_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        v48 = 1'b0;
  logic [47:0] a48 = '0, b48 = '0;
  logic        c48 = 1'b0;
  logic [5:0]  s48 = '0;
  logic        ov48, co48;
  logic [47:0] sh48, su48;

  logic        v64 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0;
  logic        c64 = 1'b0;
  logic [5:0]  s64 = '0;
  logic        ov64, co64;
  logic [63:0] sh64, su64;

  int checks = 0;
  int errors = 0;

  shift_add_unit #(.WIDTH(48), .SHAMT_W(6)) u48 (
    .clk(clk), .rst_n(rst_n), .in_valid(v48),
    .a(a48), .b(b48), .cin(c48), .shamt(s48),
    .out_valid(ov48), .shifted(sh48), .sum(su48), .cout(co48)
  );

  shift_add_unit #(.WIDTH(64), .SHAMT_W(6)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64),
    .a(a64), .b(b64), .cin(c64), .shamt(s64),
    .out_valid(ov64), .shifted(sh64), .sum(su64), .cout(co64)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] a;
    logic [47:0] b;
    logic        cin;
    logic [5:0]  sh;
    logic [47:0] esh;
    logic [47:0] esum;
    logic        ecout;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: shift beyond the word is zero, add in one wider word.
  function automatic logic [47:0] rsh48(input logic [47:0] a,
                                        input logic [5:0] s);
    return (s >= 6'd48) ? 48'd0 : a << s;
  endfunction

  function automatic logic [48:0] radd48(input logic [47:0] x,
                                         input logic [47:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + {48'd0, ci};
  endfunction

  function automatic logic [64:0] radd64(input logic [63:0] x,
                                         input logic [63:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + {64'd0, ci};
  endfunction

  logic [63:0] r;
  logic [47:0] e_sh48, e_su48;
  logic        e_co48, e_v48;
  logic [48:0] t48;
  logic [63:0] e_sh64, e_su64;
  logic        e_co64, e_v64;
  logic [64:0] t64;

  initial begin
    tbl[0] = '{48'd12, 48'd0, 1'b0, 6'd0, 48'd12, 48'd12, 1'b0};
    tbl[1] = '{48'd12, 48'd12, 1'b0, 6'd2, 48'd48, 48'd60, 1'b0};
    tbl[2] = '{48'd12, 48'd60, 1'b0, 6'd3, 48'd96, 48'd156, 1'b0};
    tbl[3] = '{48'hFFFF_FFFF_FFFF, 48'd0, 1'b1, 6'd0,
               48'hFFFF_FFFF_FFFF, 48'd0, 1'b1};
    tbl[4] = '{48'd1, 48'd5, 1'b0, 6'd47,
               48'h8000_0000_0000, 48'h8000_0000_0005, 1'b0};
    tbl[5] = '{48'd1, 48'd5, 1'b0, 6'd48, 48'd0, 48'd5, 1'b0};
    tbl[6] = '{48'hFFFF_FFFF_FFFF, 48'd5, 1'b0, 6'd63,
               48'd0, 48'd5, 1'b0};

    #2;
    chk("rst_ov48", {63'd0, ov48}, 64'd0);
    chk("rst_su48", {16'd0, su48}, 64'd0);
    chk("rst_sh48", {16'd0, sh48}, 64'd0);
    chk("rst_co64", {63'd0, co64}, 64'd0);
    chk("rst_su64", su64, 64'd0);
    #10 rst_n = 1'b1;
    cyc();

    // Back-to-back table vectors, one result per cycle.
    for (int i = 0; i < 7; i++) begin
      v48 = 1'b1; a48 = tbl[i].a; b48 = tbl[i].b;
      c48 = tbl[i].cin; s48 = tbl[i].sh;
      cyc();
      chk($sformatf("tbl%0d_ov", i), {63'd0, ov48}, 64'd1);
      chk($sformatf("tbl%0d_sh", i), {16'd0, sh48}, {16'd0, tbl[i].esh});
      chk($sformatf("tbl%0d_sum", i), {16'd0, su48}, {16'd0, tbl[i].esum});
      chk($sformatf("tbl%0d_co", i), {63'd0, co48}, {63'd0, tbl[i].ecout});
    end

    // Hold: one valid then three idle cycles.
    v48 = 1'b1; a48 = 48'h1234; b48 = 48'h77; c48 = 1'b1; s48 = 6'd4;
    cyc();
    chk("hold_ov_hi", {63'd0, ov48}, 64'd1);
    chk("hold_sum0", {16'd0, su48}, 64'h123_40 + 64'h78);
    v48 = 1'b0; a48 = 48'hFFFF; b48 = 48'h1; c48 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("hold%0d_ov", i), {63'd0, ov48}, 64'd0);
      chk($sformatf("hold%0d_sum", i), {16'd0, su48}, 64'h123_40 + 64'h78);
      chk($sformatf("hold%0d_sh", i), {16'd0, sh48}, 64'h123_40);
      chk($sformatf("hold%0d_co", i), {63'd0, co48}, 64'd0);
    end

    // WIDTH=64 carry chain and byte shift.
    v64 = 1'b1; a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = '0; c64 = 1'b1;
    s64 = 6'd0;
    cyc();
    chk("w64_carry_sum", su64, 64'd0);
    chk("w64_carry_co", {63'd0, co64}, 64'd1);
    chk("w64_carry_ov", {63'd0, ov64}, 64'd1);
    a64 = 64'h0000_0000_00B4_851F; c64 = 1'b0; s64 = 6'd8;
    cyc();
    chk("w64_sh", sh64, 64'h0000_0000_B485_1F00);
    chk("w64_sum", su64, 64'h0000_0000_B485_1F00);
    chk("w64_co", {63'd0, co64}, 64'd0);
    v64 = 1'b0;

    // Async reset between edges while a result is pending.
    v48 = 1'b1; a48 = 48'd9; b48 = 48'd1; c48 = 1'b0; s48 = 6'd1;
    cyc();
    chk("ar_pre_ov", {63'd0, ov48}, 64'd1);
    chk("ar_pre_sum", {16'd0, su48}, 64'd19);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ov", {63'd0, ov48}, 64'd0);
    chk("ar_sum", {16'd0, su48}, 64'd0);
    chk("ar_sh", {16'd0, sh48}, 64'd0);
    chk("ar_co", {63'd0, co48}, 64'd0);
    chk("ar_sum64", su64, 64'd0);
    v48 = 1'b1; a48 = 48'd3; b48 = 48'd1; s48 = 6'd1;
    #3 rst_n = 1'b1;
    cyc();
    chk("ar_post_ov", {63'd0, ov48}, 64'd1);
    chk("ar_post_sum", {16'd0, su48}, 64'd7);

    // Randomized stimulus against the arithmetic model.
    e_sh48 = sh48; e_su48 = su48; e_co48 = co48;
    e_sh64 = sh64; e_su64 = su64; e_co64 = co64;
    for (int i = 0; i < 300; i++) begin
      v48 = ($urandom_range(0, 3) != 0);
      r = {$urandom, $urandom}; a48 = r[47:0];
      r = {$urandom, $urandom}; b48 = r[47:0];
      c48 = $urandom_range(0, 1);
      s48 = 6'($urandom_range(0, 63));
      v64 = ($urandom_range(0, 3) != 0);
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      c64 = $urandom_range(0, 1);
      s64 = 6'($urandom_range(0, 63));
      e_v48 = v48;
      if (v48) begin
        e_sh48 = rsh48(a48, s48);
        t48 = radd48(e_sh48, b48, c48);
        e_su48 = t48[47:0]; e_co48 = t48[48];
      end
      e_v64 = v64;
      if (v64) begin
        e_sh64 = a64 << s64;
        t64 = radd64(e_sh64, b64, c64);
        e_su64 = t64[63:0]; e_co64 = t64[64];
      end
      cyc();
      chk($sformatf("rnd%0d_ov48", i), {63'd0, ov48}, {63'd0, e_v48});
      chk($sformatf("rnd%0d_sh48", i), {16'd0, sh48}, {16'd0, e_sh48});
      chk($sformatf("rnd%0d_su48", i), {16'd0, su48}, {16'd0, e_su48});
      chk($sformatf("rnd%0d_co48", i), {63'd0, co48}, {63'd0, e_co48});
      chk($sformatf("rnd%0d_ov64", i), {63'd0, ov64}, {63'd0, e_v64});
      chk($sformatf("rnd%0d_sh64", i), sh64, e_sh64);
      chk($sformatf("rnd%0d_su64", i), su64, e_su64);
      chk($sformatf("rnd%0d_co64", i), {63'd0, co64}, {63'd0, e_co64});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
